trashbin_bus_bridge: RTL and testbench

Memory-bus bridge between `TrashbinCore` and the on-chip `TempRam`. Decodes each core access into RAM, memory-mapped I/O (LED register, free-running timer, status, ID) or unmapped space, and returns read data with the same one-cycle latency as the synchronous RAM. It replaces the direct core-to-RAM wiring in the SOC top level and becomes the sole driver of the board LEDs.

---
 rtl/trashbin_bus_pkg.sv | 30 +++
 rtl/trashbin_mmio_regs.sv | 91 +++++++++
 rtl/trashbin_bus_bridge.sv | 87 ++++++++
 tb/tb_trashbin_bus_bridge.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trashbin_bus_pkg.sv
// Shared constants and types for the TrashbinCore memory-bus bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package trashbin_bus_pkg;

  localparam logic [15:0] MMIO_TAG_DFLT  = 16'hFFFF;
  localparam logic [31:0] BRIDGE_ID_DFLT = 32'h7A5B_1000;

  // MMIO word offsets (AddressBus[3:0])
  localparam logic [3:0] OFF_LED     = 4'h0;
  localparam logic [3:0] OFF_TIMER   = 4'h1;
  localparam logic [3:0] OFF_COMPARE = 4'h2;
  localparam logic [3:0] OFF_STATUS  = 4'h3;
  localparam logic [3:0] OFF_ID      = 4'h4;

  // STATUS register bit positions
  localparam int STATUS_MATCH  = 0;
  localparam int STATUS_BUSERR = 1;

  localparam int LED_RED_BITS   = 10;
  localparam int LED_GREEN_BITS = 8;
  localparam int LED_BITS       = LED_RED_BITS + LED_GREEN_BITS;

  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_MMIO,
    SEL_NONE
  } bus_sel_t;

endpackage

// File: rtl/trashbin_mmio_regs.sv
// MMIO register file: LED, free-running TIMER, COMPARE, STATUS (W1C) and ID.
// Latency: writes visible next cycle; readData is registered (1 cycle).
// Backpressure: none, every access completes in the cycle it is presented.
//
// Ports: clk/resetN (sync, active-low); regSelect = valid MMIO register window;
// regOffset/writeData/writeStrobe = access; busError = unmapped access this
// cycle; ledRed/ledGreen = LED register fields; readData = registered read.
module trashbin_mmio_regs
  import trashbin_bus_pkg::*;
#(
  parameter logic [31:0] BRIDGE_ID = BRIDGE_ID_DFLT
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      regSelect,
  input  logic [3:0]                regOffset,
  input  logic [31:0]               writeData,
  input  logic                      writeStrobe,
  input  logic                      busError,
  output logic [LED_RED_BITS-1:0]   ledRed,
  output logic [LED_GREEN_BITS-1:0] ledGreen,
  output logic [31:0]               readData
);

  logic [LED_BITS-1:0] ledReg;
  logic [31:0]         timerReg;
  logic [31:0]         compareReg;
  logic [1:0]          statusReg;

  logic        regWrite;
  logic [31:0] readValue;
  logic [1:0]  statusSet;
  logic [1:0]  statusClear;

  assign regWrite = regSelect & writeStrobe;
  assign ledRed   = ledReg[LED_RED_BITS-1:0];
  assign ledGreen = ledReg[LED_BITS-1:LED_RED_BITS];

  // Read value is the pre-edge register content, so a TIMER read sees the
  // count before this cycle's increment.
  always_comb begin
    readValue = 32'd0;
    if (regSelect) begin
      case (regOffset)
        OFF_LED:     readValue = {{(32-LED_BITS){1'b0}}, ledReg};
        OFF_TIMER:   readValue = timerReg;
        OFF_COMPARE: readValue = compareReg;
        OFF_STATUS:  readValue = {30'd0, statusReg};
        OFF_ID:      readValue = BRIDGE_ID;
        default:     readValue = 32'd0;
      endcase
    end
  end

  always_comb begin
    statusSet                = 2'b00;
    statusSet[STATUS_MATCH]  = (timerReg == compareReg);
    statusSet[STATUS_BUSERR] = busError;
    statusClear              = 2'b00;
    if (regWrite && regOffset == OFF_STATUS) begin
      statusClear = writeData[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      ledReg     <= '0;
      timerReg   <= 32'd0;
      compareReg <= 32'hFFFF_FFFF;
      statusReg  <= 2'b00;
      readData   <= 32'd0;
    end else begin
      if (regWrite && regOffset == OFF_LED) begin
        ledReg <= writeData[LED_BITS-1:0];
      end
      // A TIMER write replaces the increment for that cycle.
      if (regWrite && regOffset == OFF_TIMER) begin
        timerReg <= writeData;
      end else begin
        timerReg <= timerReg + 32'd1;
      end
      if (regWrite && regOffset == OFF_COMPARE) begin
        compareReg <= writeData;
      end
      // Clear first, then OR in new events so a coincident set survives.
      statusReg <= (statusReg & ~statusClear) | statusSet;
      readData  <= readValue;
    end
  end

endmodule

// File: rtl/trashbin_bus_bridge.sv
// TrashbinCore bus bridge: decodes RAM / MMIO / unmapped, muxes read data.
// Latency: RAM controls combinational; read data 1 cycle after address.
// Backpressure: none, the bridge never stalls the core.
//
// Ports: CoreClock/ResetN (sync, active-low); AddressBus/DataWriteBus/
// WriteAssert from the core; DataReadBus to the core; RamAddress/
// RamWriteData/RamWriteEnable/RamReadData to/from TempRam; LEDS/LEDS_G boards.
module trashbin_bus_bridge
  import trashbin_bus_pkg::*;
#(
  parameter int          RAM_ADDR_BITS = 14,
  parameter logic [15:0] MMIO_TAG      = MMIO_TAG_DFLT,
  parameter logic [31:0] BRIDGE_ID     = BRIDGE_ID_DFLT
) (
  input  logic                     CoreClock,
  input  logic                     ResetN,
  input  logic [31:0]              AddressBus,
  input  logic [31:0]              DataWriteBus,
  input  logic                     WriteAssert,
  output logic [31:0]              DataReadBus,
  output logic [RAM_ADDR_BITS-1:0] RamAddress,
  output logic [31:0]              RamWriteData,
  output logic                     RamWriteEnable,
  input  logic [31:0]              RamReadData,
  output logic [9:0]               LEDS,
  output logic [7:0]               LEDS_G
);

  bus_sel_t    busSel;
  bus_sel_t    busSelQ;
  logic        regSelect;
  logic        busError;
  logic [31:0] mmioReadData;

  always_comb begin
    busSel = SEL_NONE;
    if (AddressBus[31:RAM_ADDR_BITS] == '0) begin
      busSel = SEL_RAM;
    end else if (AddressBus[31:16] == MMIO_TAG) begin
      busSel = SEL_MMIO;
    end
  end

  // Only the first 16 words of the MMIO page hold registers; the rest of the
  // page is a silent hole rather than a bus error.
  assign regSelect = (busSel == SEL_MMIO) && (AddressBus[15:4] == 12'd0);
  assign busError  = (busSel == SEL_NONE);

  assign RamAddress     = AddressBus[RAM_ADDR_BITS-1:0];
  assign RamWriteData   = DataWriteBus;
  // Gating with ResetN keeps a write issued during reset out of the RAM.
  assign RamWriteEnable = WriteAssert && (busSel == SEL_RAM) && ResetN;

  trashbin_mmio_regs #(
    .BRIDGE_ID (BRIDGE_ID)
  ) mmioRegs (
    .clk         (CoreClock),
    .resetN      (ResetN),
    .regSelect   (regSelect),
    .regOffset   (AddressBus[3:0]),
    .writeData   (DataWriteBus),
    .writeStrobe (WriteAssert),
    .busError    (busError),
    .ledRed      (LEDS),
    .ledGreen    (LEDS_G),
    .readData    (mmioReadData)
  );

  // Select is delayed to line up with the RAM's internal read register.
  always_ff @(posedge CoreClock) begin
    if (!ResetN) begin
      busSelQ <= SEL_NONE;
    end else begin
      busSelQ <= busSel;
    end
  end

  always_comb begin
    DataReadBus = 32'd0;
    case (busSelQ)
      SEL_RAM:  DataReadBus = RamReadData;
      SEL_MMIO: DataReadBus = mmioReadData;
      default:  DataReadBus = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_trashbin_bus_bridge.sv
module tb_trashbin_bus_bridge;

  localparam int RAM_BITS = 14;
  localparam int RAM_WORDS = 1 << RAM_BITS;
  localparam logic [31:0] ID_VALUE = 32'h7A5B_1000;

  logic                CoreClock = 1'b0;
  logic                ResetN;
  logic [31:0]         AddressBus;
  logic [31:0]         DataWriteBus;
  logic                WriteAssert;
  logic [31:0]         DataReadBus;
  logic [RAM_BITS-1:0] RamAddress;
  logic [31:0]         RamWriteData;
  logic                RamWriteEnable;
  logic [31:0]         RamReadData;
  logic [9:0]          LEDS;
  logic [7:0]          LEDS_G;

  always #5 CoreClock = ~CoreClock;

  trashbin_bus_bridge #(
    .RAM_ADDR_BITS (RAM_BITS),
    .MMIO_TAG      (16'hFFFF),
    .BRIDGE_ID     (ID_VALUE)
  ) dut (
    .CoreClock      (CoreClock),
    .ResetN         (ResetN),
    .AddressBus     (AddressBus),
    .DataWriteBus   (DataWriteBus),
    .WriteAssert    (WriteAssert),
    .DataReadBus    (DataReadBus),
    .RamAddress     (RamAddress),
    .RamWriteData   (RamWriteData),
    .RamWriteEnable (RamWriteEnable),
    .RamReadData    (RamReadData),
    .LEDS           (LEDS),
    .LEDS_G         (LEDS_G)
  );

  // TempRam stand-in: synchronous, registered read of the pre-write word.
  logic [31:0] ramMem [RAM_WORDS];
  initial begin
    for (int i = 0; i < RAM_WORDS; i++) ramMem[i] = 32'd0;
    RamReadData = 32'd0;
  end
  always @(posedge CoreClock) begin
    RamReadData <= ramMem[RamAddress];
    if (RamWriteEnable) ramMem[RamAddress] <= RamWriteData;
  end

  int assertCount = 0;
  int failCount   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural register state plus the word the core
  // should see on DataReadBus in the current cycle.
  bit          mValid = 1'b0;
  logic [17:0] mLed;
  logic [31:0] mTimer;
  logic [31:0] mCompare;
  logic [1:0]  mStatus;
  logic [31:0] mExpRead;
  logic [31:0] refMem [RAM_WORDS];
  initial for (int i = 0; i < RAM_WORDS; i++) refMem[i] = 32'd0;

  task automatic modelEdge(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    bit isRam, isMmio, isNone, regOk, matchNow;
    logic [31:0] rd, nextTimer;
    logic [1:0] clr;
    isRam  = (a[31:RAM_BITS] == 0);
    isMmio = (a[31:16] == 16'hFFFF);
    isNone = !isRam && !isMmio;
    regOk  = isMmio && (a[15:4] == 0);
    if (!r) begin
      mValid = 1'b1;
      mLed = 18'd0; mTimer = 32'd0; mCompare = 32'hFFFF_FFFF;
      mStatus = 2'b00; mExpRead = 32'd0;
      return;
    end
    matchNow = (mTimer == mCompare);
    rd = 32'd0;
    if (isRam) rd = refMem[a[RAM_BITS-1:0]];
    else if (regOk) begin
      case (a[3:0])
        4'h0: rd = {14'd0, mLed};
        4'h1: rd = mTimer;
        4'h2: rd = mCompare;
        4'h3: rd = {30'd0, mStatus};
        4'h4: rd = ID_VALUE;
        default: rd = 32'd0;
      endcase
    end
    if (isRam && w) refMem[a[RAM_BITS-1:0]] = d;
    clr = 2'b00;
    nextTimer = mTimer + 1;
    if (regOk && w) begin
      case (a[3:0])
        4'h0: mLed = d[17:0];
        4'h1: nextTimer = d;
        4'h2: mCompare = d;
        4'h3: clr = d[1:0];
        default: ;
      endcase
    end
    mStatus  = (mStatus & ~clr) | {isNone, matchNow};
    mTimer   = nextTimer;
    mExpRead = rd;
  endtask

  // Hand-written expectations for the cycle after a table entry.
  bit          pendRead = 1'b0;
  logic [31:0] pendReadExp;
  bit          pendLed = 1'b0;
  logic [17:0] pendLedExp;
  string       pendName;

  task automatic runCycle(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    AddressBus   = a;
    DataWriteBus = d;
    WriteAssert  = w;
    ResetN       = r;
    @(negedge CoreClock);
    if (mValid) begin
      check("ramWe",    {31'd0, RamWriteEnable}, {31'd0, (r && w && (a[31:RAM_BITS] == 0))});
      check("ramAddr",  {18'd0, RamAddress}, {18'd0, a[RAM_BITS-1:0]});
      check("ramWdata", RamWriteData, d);
      check("leds",     {22'd0, LEDS}, {22'd0, mLed[9:0]});
      check("ledsG",    {24'd0, LEDS_G}, {24'd0, mLed[17:10]});
      check("readData", DataReadBus, mExpRead);
    end
    if (pendRead) check({pendName, ".read"}, DataReadBus, pendReadExp);
    if (pendLed)  check({pendName, ".led"}, {14'd0, LEDS_G, LEDS}, {14'd0, pendLedExp});
    pendRead = 1'b0;
    pendLed  = 1'b0;
    @(posedge CoreClock);
    modelEdge(a, d, w, r);
    #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic        rstn;
    bit          chkRead;
    logic [31:0] expRead;
    bit          chkLed;
    logic [17:0] expLed;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input string name, input logic [31:0] a, input logic [31:0] d,
                                 input logic w, input logic r, input bit cr, input logic [31:0] er,
                                 input bit cl, input logic [17:0] el);
    vec_t v;
    v.addr = a; v.data = d; v.we = w; v.rstn = r;
    v.chkRead = cr; v.expRead = er; v.chkLed = cl; v.expLed = el; v.name = name;
    vecs.push_back(v);
  endfunction

  function automatic void idle(input int n);
    for (int i = 0; i < n; i++) addVec("idle", 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 18'd0);
  endfunction

  initial begin
    AddressBus = 32'd0; DataWriteBus = 32'd0; WriteAssert = 1'b0; ResetN = 1'b0;
    #1;

    // Reset and timer/ID after reset
    addVec("rst0",     32'd0,         32'd0,        1'b0, 1'b0, 0, 32'd0,         0, 18'd0);
    addVec("rst1",     32'd0,         32'd0,        1'b0, 1'b0, 1, 32'd0,         1, 18'd0);
    idle(5);
    addVec("timer5",   32'hFFFF_0001, 32'd0,        1'b0, 1'b1, 1, 32'd5,         0, 18'd0);
    addVec("id",       32'hFFFF_0004, 32'd0,        1'b0, 1'b1, 1, ID_VALUE,      0, 18'd0);
    addVec("idWr",     32'hFFFF_0004, 32'd0,        1'b1, 1'b1, 0, 32'd0,         0, 18'd0);
    addVec("idRo",     32'hFFFF_0004, 32'd0,        1'b0, 1'b1, 1, ID_VALUE,      0, 18'd0);
    // LED register
    addVec("ledWr",    32'hFFFF_0000, 32'h0003_FFFF, 1'b1, 1'b1, 0, 32'd0,        1, 18'h3FFFF);
    addVec("ledRd",    32'hFFFF_0000, 32'd0,        1'b0, 1'b1, 1, 32'h0003_FFFF, 0, 18'd0);
    addVec("ledWrAll", 32'hFFFF_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 0, 32'd0,        1, 18'h3FFFF);
    addVec("ledRdUp",  32'hFFFF_0000, 32'd0,        1'b0, 1'b1, 1, 32'h0003_FFFF, 0, 18'd0);
    addVec("ledWrMix", 32'hFFFF_0000, 32'hABCD_E123, 1'b1, 1'b1, 0, 32'd0,        1, 18'h1E123);
    addVec("ledRdMix", 32'hFFFF_0000, 32'd0,        1'b0, 1'b1, 1, 32'h0001_E123, 0, 18'd0);
    // RAM write then read
    addVec("ramWr",    32'h0000_0123, 32'hDEAD_BEEF, 1'b1, 1'b1, 0, 32'd0,        0, 18'd0);
    addVec("ramRd",    32'h0000_0123, 32'd0,        1'b0, 1'b1, 1, 32'hDEAD_BEEF, 0, 18'd0);
    // Unmapped access and BUSERR
    addVec("noneWr",   32'h0001_0000, 32'h55,       1'b1, 1'b1, 1, 32'd0,         0, 18'd0);
    addVec("statErr",  32'hFFFF_0003, 32'd0,        1'b0, 1'b1, 1, 32'd2,         0, 18'd0);
    addVec("w1cErr",   32'hFFFF_0003, 32'd2,        1'b1, 1'b1, 0, 32'd0,         0, 18'd0);
    addVec("statClr",  32'hFFFF_0003, 32'd0,        1'b0, 1'b1, 1, 32'd0,         0, 18'd0);
    addVec("hole",     32'hFFFF_0010, 32'd0,        1'b0, 1'b1, 1, 32'd0,         0, 18'd0);
    addVec("holeNoErr",32'hFFFF_0003, 32'd0,        1'b0, 1'b1, 1, 32'd0,         0, 18'd0);
    // COMPARE / TIMER match
    addVec("cmpWr",    32'hFFFF_0002, 32'd10,       1'b1, 1'b1, 0, 32'd0,         0, 18'd0);
    addVec("tmrWr",    32'hFFFF_0001, 32'd0,        1'b1, 1'b1, 0, 32'd0,         0, 18'd0);
    idle(11);
    addVec("match",    32'hFFFF_0003, 32'd0,        1'b0, 1'b1, 1, 32'd1,         0, 18'd0);
    addVec("w1cMatch", 32'hFFFF_0003, 32'd1,        1'b1, 1'b1, 0, 32'd0,         0, 18'd0);
    addVec("matchClr", 32'hFFFF_0003, 32'd0,        1'b0, 1'b1, 1, 32'd0,         0, 18'd0);
    addVec("tmr10a",   32'hFFFF_0001, 32'd10,       1'b1, 1'b1, 0, 32'd0,         0, 18'd0);
    addVec("tmr10b",   32'hFFFF_0001, 32'd10,       1'b1, 1'b1, 0, 32'd0,         0, 18'd0);
    addVec("w1cRace",  32'hFFFF_0003, 32'd1,        1'b1, 1'b1, 0, 32'd0,         0, 18'd0);
    addVec("setWins",  32'hFFFF_0003, 32'd0,        1'b0, 1'b1, 1, 32'd1,         0, 18'd0);
    // Reset during a RAM write
    addVec("ledSet",   32'hFFFF_0000, 32'h0003_FFFF, 1'b1, 1'b1, 0, 32'd0,        1, 18'h3FFFF);
    addVec("rstWr",    32'h0000_0123, 32'h1111_1111, 1'b1, 1'b0, 1, 32'd0,        1, 18'd0);
    addVec("rstTimer", 32'hFFFF_0001, 32'd0,        1'b0, 1'b1, 1, 32'd0,         0, 18'd0);
    addVec("rstCmp",   32'hFFFF_0002, 32'd0,        1'b0, 1'b1, 1, 32'hFFFF_FFFF, 0, 18'd0);
    addVec("rstStat",  32'hFFFF_0003, 32'd0,        1'b0, 1'b1, 1, 32'd0,         0, 18'd0);
    addVec("rstRam",   32'h0000_0123, 32'd0,        1'b0, 1'b1, 1, 32'hDEAD_BEEF, 0, 18'd0);
    addVec("rstLed",   32'hFFFF_0000, 32'd0,        1'b0, 1'b1, 1, 32'd0,         0, 18'd0);
    idle(1);

    foreach (vecs[i]) begin
      runCycle(vecs[i].addr, vecs[i].data, vecs[i].we, vecs[i].rstn);
      pendName    = vecs[i].name;
      pendRead    = vecs[i].chkRead;
      pendReadExp = vecs[i].expRead;
      pendLed     = vecs[i].chkLed;
      pendLedExp  = vecs[i].expLed;
    end

    // Randomized traffic checked against the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, d;
      logic w, r;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = {18'd0, 14'($urandom_range(0, 31))};
        4, 5, 6, 7: a = {16'hFFFF, 12'd0, 4'($urandom_range(0, 7))};
        8:          a = {16'hFFFF, 12'($urandom_range(1, 4095)), 4'($urandom)};
        default:    a = {16'($urandom_range(1, 16'hFFFE)), 16'($urandom)};
      endcase
      d = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 20)) : $urandom;
      w = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 99) != 0);
      runCycle(a, d, w, r);
    end
    runCycle(32'd0, 32'd0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
